// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: CPU port, two DMA requester ports, one memory port.
// Pure signal bundle, no logic; latency is defined by the arbiter using it.
// Backpressure is carried by cpu_ce and dmaN_gnt, which the arbiter drives.
interface mem_arbiter_if;
    // CPU side
    logic [31:0] cpu_a;
    logic [31:0] cpu_o;
    logic        cpu_w;
    logic [31:0] cpu_i;
    logic        cpu_ce;
    // DMA requester 0
    logic        dma0_req;
    logic [31:0] dma0_a;
    logic [31:0] dma0_o;
    logic        dma0_w;
    logic        dma0_gnt;
    logic        dma0_rvalid;
    logic [31:0] dma0_i;
    // DMA requester 1
    logic        dma1_req;
    logic [31:0] dma1_a;
    logic [31:0] dma1_o;
    logic        dma1_w;
    logic        dma1_gnt;
    logic        dma1_rvalid;
    logic [31:0] dma1_i;
    // Shared memory port
    logic [31:0] mem_a;
    logic [31:0] mem_o;
    logic        mem_w;
    logic [31:0] mem_i;

    // Arbiter view
    modport slave (
        input  cpu_a, cpu_o, cpu_w,
        output cpu_i, cpu_ce,
        input  dma0_req, dma0_a, dma0_o, dma0_w,
        output dma0_gnt, dma0_rvalid, dma0_i,
        input  dma1_req, dma1_a, dma1_o, dma1_w,
        output dma1_gnt, dma1_rvalid, dma1_i,
        output mem_a, mem_o, mem_w,
        input  mem_i
    );

    // Requester / memory view
    modport master (
        output cpu_a, cpu_o, cpu_w,
        input  cpu_i, cpu_ce,
        output dma0_req, dma0_a, dma0_o, dma0_w,
        input  dma0_gnt, dma0_rvalid, dma0_i,
        output dma1_req, dma1_a, dma1_o, dma1_w,
        input  dma1_gnt, dma1_rvalid, dma1_i,
        input  mem_a, mem_o, mem_w,
        output mem_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between a CPU and two round-robin DMA requesters, one owner per cycle.
// Grant is combinational (zero latency); DMA read data returns with rvalid one cycle after grant.
// DMA bursts are capped at MAX_BURST slots, then one forced CPU slot; ungranted DMA requests are held.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] C_MAX = 4'(MAX_BURST);

    logic [3:0]  r_burst_cnt;
    logic        r_rr_ptr;
    logic        r_rd_vld;
    logic        r_rd_own;

    logic        w_dma_slot;
    logic        w_sel1;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_o;
    logic        w_sel_w;

    // Ownership decision: DMA wins unless the burst budget is spent; tie broken by rr pointer
    always_comb begin
        w_dma_slot = (bus.dma0_req | bus.dma1_req) && (r_burst_cnt < C_MAX);
        w_sel1     = bus.dma1_req && (!bus.dma0_req || r_rr_ptr);
    end

    // Memory port mux; CPU strobe can only reach mem_w in CPU-owned cycles
    always_comb begin
        w_sel_a = bus.cpu_a;
        w_sel_o = bus.cpu_o;
        w_sel_w = bus.cpu_w;
        if (w_dma_slot) begin
            if (w_sel1) begin
                w_sel_a = bus.dma1_a;
                w_sel_o = bus.dma1_o;
                w_sel_w = bus.dma1_w;
            end else begin
                w_sel_a = bus.dma0_a;
                w_sel_o = bus.dma0_o;
                w_sel_w = bus.dma0_w;
            end
        end
    end

    assign bus.mem_a       = w_sel_a;
    assign bus.mem_o       = w_sel_o;
    assign bus.mem_w       = !reset && w_sel_w;
    assign bus.cpu_ce      = !reset && !w_dma_slot;
    assign bus.dma0_gnt    = !reset && w_dma_slot && !w_sel1;
    assign bus.dma1_gnt    = !reset && w_dma_slot && w_sel1;
    // Reset also masks a tag left over from the cycle before reset
    assign bus.dma0_rvalid = !reset && r_rd_vld && !r_rd_own;
    assign bus.dma1_rvalid = !reset && r_rd_vld && r_rd_own;
    assign bus.cpu_i       = bus.mem_i;
    assign bus.dma0_i      = bus.mem_i;
    assign bus.dma1_i      = bus.mem_i;

    // Burst counter, round-robin pointer and read-return tag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst_cnt <= 4'd0;
            r_rr_ptr    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_own    <= 1'b0;
        end else if (w_dma_slot) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
            r_rr_ptr    <= !w_sel1;
            r_rd_vld    <= !w_sel_w;
            r_rd_own    <= w_sel1;
        end else begin
            r_burst_cnt <= 4'd0;
            r_rd_vld    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic against a reference model.
// Inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Requesters hold a request until the model says it was granted.
module tb_mem_arbiter;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_BURST(MB)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Stimulus variables
    logic [31:0] c_a, c_o;
    logic        c_w;
    logic        t_req [2];
    logic [31:0] t_a   [2];
    logic [31:0] t_o   [2];
    logic        t_w   [2];

    assign bus.cpu_a    = c_a;
    assign bus.cpu_o    = c_o;
    assign bus.cpu_w    = c_w;
    assign bus.dma0_req = t_req[0];
    assign bus.dma0_a   = t_a[0];
    assign bus.dma0_o   = t_o[0];
    assign bus.dma0_w   = t_w[0];
    assign bus.dma1_req = t_req[1];
    assign bus.dma1_a   = t_a[1];
    assign bus.dma1_o   = t_o[1];
    assign bus.dma1_w   = t_w[1];

    // Memory attached to the shared port: write on edge, registered read
    logic [31:0] tbmem [0:4095];
    always @(posedge clk) begin
        if (bus.mem_w) tbmem[bus.mem_a[13:2]] <= bus.mem_o;
        bus.mem_i <= tbmem[bus.mem_a[13:2]];
    end

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          m_streak;    // DMA slots since the last CPU slot
    int          m_next;      // DMA that wins a tie
    int          m_rv_own;    // DMA owed read data this cycle, -1 none
    bit          m_rv_known;
    logic [31:0] m_rv_dat;
    int          m_owner;     // owner of the last stepped cycle: 0/1 DMA, 2 CPU, -1 reset
    logic [31:0] shadow [int];

    // Observed outputs of the last stepped cycle
    logic        o_gnt0, o_gnt1, o_ce, o_rv0, o_rv1;
    logic [31:0] o_d1i;

    task automatic step();
        int          own;
        int          idx;
        logic [31:0] e_a, e_o;
        logic        e_w;
        #5;
        o_gnt0 = bus.dma0_gnt;
        o_gnt1 = bus.dma1_gnt;
        o_ce   = bus.cpu_ce;
        o_rv0  = bus.dma0_rvalid;
        o_rv1  = bus.dma1_rvalid;
        o_d1i  = bus.dma1_i;
        chk("cpu_i_pass", bus.cpu_i, bus.mem_i);
        chk("dma0_i_pass", bus.dma0_i, bus.mem_i);
        if (rst) begin
            chk("rst_gnt0", 32'(o_gnt0), 32'd0);
            chk("rst_gnt1", 32'(o_gnt1), 32'd0);
            chk("rst_cpu_ce", 32'(o_ce), 32'd0);
            chk("rst_mem_w", 32'(bus.mem_w), 32'd0);
            chk("rst_rvalid0", 32'(o_rv0), 32'd0);
            chk("rst_rvalid1", 32'(o_rv1), 32'd0);
            m_streak = 0;
            m_next   = 0;
            m_rv_own = -1;
            m_owner  = -1;
        end else begin
            own = 2;
            if ((t_req[0] || t_req[1]) && m_streak < MB) begin
                if (t_req[0] && t_req[1]) own = m_next;
                else if (t_req[0])        own = 0;
                else                      own = 1;
            end
            if (own == 2) begin
                e_a = c_a; e_o = c_o; e_w = c_w;
            end else begin
                e_a = t_a[own]; e_o = t_o[own]; e_w = t_w[own];
            end
            chk("gnt0", 32'(o_gnt0), 32'(own == 0));
            chk("gnt1", 32'(o_gnt1), 32'(own == 1));
            chk("cpu_ce", 32'(o_ce), 32'(own == 2));
            chk("mem_a", bus.mem_a, e_a);
            chk("mem_o", bus.mem_o, e_o);
            chk("mem_w", 32'(bus.mem_w), 32'(e_w));
            chk("rvalid0", 32'(o_rv0), 32'(m_rv_own == 0));
            chk("rvalid1", 32'(o_rv1), 32'(m_rv_own == 1));
            if (m_rv_own >= 0 && m_rv_known)
                chk("rdata", (m_rv_own == 0) ? bus.dma0_i : bus.dma1_i, m_rv_dat);
            idx = int'(e_a[13:2]);
            if (own < 2) begin
                m_streak++;
                m_next = 1 - own;
                if (!e_w) begin
                    m_rv_own   = own;
                    m_rv_known = shadow.exists(idx);
                    if (m_rv_known) m_rv_dat = shadow[idx];
                end else begin
                    shadow[idx] = e_o;
                    m_rv_own    = -1;
                end
            end else begin
                m_streak = 0;
                m_rv_own = -1;
                if (e_w) shadow[idx] = e_o;
            end
            m_owner = own;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  pat_ce, pat_gnt, seq;
        logic [31:0] code;
        n_chk = 0; n_fail = 0;
        m_streak = 0; m_next = 0; m_rv_own = -1; m_rv_known = 0; m_rv_dat = '0; m_owner = -1;
        rst = 1'b1;
        c_a = '0; c_o = '0; c_w = 1'b0;
        for (int n = 0; n < 2; n++) begin
            t_req[n] = 1'b0; t_a[n] = '0; t_o[n] = '0; t_w[n] = 1'b0;
        end
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // CPU alone writes 0xDEADBEEF to byte 0x100 every cycle
        c_a = 32'h100; c_o = 32'hDEADBEEF; c_w = 1'b1;
        repeat (3) step();
        chk("cpu_ce_alone", 32'(o_ce), 32'd1);
        chk("word40", tbmem[12'h040], 32'hDEADBEEF);

        // DMA1 read of 0x200 returns the word planted by the CPU, exactly one cycle later
        c_a = 32'h200; c_o = 32'h12345678; step();
        c_w = 1'b0; c_a = '0;
        t_req[1] = 1'b1; t_a[1] = 32'h200; t_w[1] = 1'b0; t_o[1] = '0;
        step();
        chk("d1_gnt_N", 32'(o_gnt1), 32'd1);
        t_req[1] = 1'b0;
        step();
        chk("d1_rvalid_N1", 32'(o_rv1), 32'd1);
        chk("d1_data_N1", o_d1i, 32'h12345678);
        chk("d0_rvalid_N1", 32'(o_rv0), 32'd0);
        step();
        chk("d1_rvalid_N2", 32'(o_rv1), 32'd0);

        // DMA0 held for 10 cycles: four DMA slots then one forced CPU slot
        rst = 1'b1; step(); rst = 1'b0;
        pat_ce = '0; pat_gnt = '0;
        t_req[0] = 1'b1; t_w[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            t_a[0] = $urandom & 32'hFFF0_00FF;
            t_o[0] = $urandom;
            step();
            pat_ce[i]  = o_ce;
            pat_gnt[i] = o_gnt0;
        end
        chk("burst_ce_pattern", 32'(pat_ce), 32'h210);
        chk("burst_gnt_pattern", 32'(pat_gnt), 32'h1EF);
        t_req[0] = 1'b0;

        // Both DMAs held: D0,D1,D0,D1 then CPU
        rst = 1'b1; step(); rst = 1'b0;
        t_req[0] = 1'b1; t_req[1] = 1'b1;
        seq = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            code = o_gnt0 ? 32'd0 : (o_gnt1 ? 32'd1 : 32'd2);
            seq  = seq | 10'(code << (2 * i));
        end
        chk("rr_sequence", 32'(seq), 32'h244);
        t_req[0] = 1'b0; t_req[1] = 1'b0;

        // DMA0 write wins over a pending CPU write; CPU write lands in its next slot
        rst = 1'b1; step(); rst = 1'b0;
        c_a = 32'h300; c_o = 32'h0; c_w = 1'b1; step();
        c_o = 32'hCAFEF00D;
        t_req[0] = 1'b1; t_a[0] = 32'h304; t_o[0] = 32'hA5A55A5A; t_w[0] = 1'b1;
        step();
        chk("cpu_wr_blocked", tbmem[12'h0C0], 32'h0);
        chk("dma_wr_applied", tbmem[12'h0C1], 32'hA5A55A5A);
        t_req[0] = 1'b0;
        step();
        chk("cpu_wr_later", tbmem[12'h0C0], 32'hCAFEF00D);
        c_w = 1'b0;

        // Reset right after a DMA0 read grant kills the pending read return
        t_req[0] = 1'b1; t_a[0] = 32'h304; t_w[0] = 1'b0;
        step();
        chk("d0_gnt_pre_rst", 32'(o_gnt0), 32'd1);
        t_req[0] = 1'b0; rst = 1'b1;
        step();
        chk("rv0_in_rst", 32'(o_rv0), 32'd0);
        rst = 1'b0;
        step();
        chk("rv0_post_rst", 32'(o_rv0), 32'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(99) == 0);
            c_a = $urandom & 32'hFFF0_00FF;
            c_o = $urandom;
            c_w = $urandom_range(1) == 1;
            for (int n = 0; n < 2; n++) begin
                if (!t_req[n] && $urandom_range(99) < 55) begin
                    t_req[n] = 1'b1;
                    t_a[n]   = $urandom & 32'hFFF0_00FF;
                    t_o[n]   = $urandom;
                    t_w[n]   = $urandom_range(1) == 1;
                end
            end
            step();
            for (int n = 0; n < 2; n++)
                if (m_owner == n) t_req[n] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
